ssd_scan_driver: RTL

//  Parametrised time-multiplexed N-digit 7-segment driver: full hex decode (0-F), per-digit decimal point,
//  PWM brightness, and a double-buffered load port so a new value never tears mid-frame. Sits between

---
 rtl/ssd_scan_driver.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
//   Time-multiplexed N-digit 7-segment driver. It provides:
//   - full hex decode (0-F)
//   - a decimal point per digit
//   - PWM brightness
//   - a double-buffered load port, so a value loaded mid-frame is shown only from the
//     next frame start and a frame never mixes old and new digits.
//
// Build option:
//   LEADING_ZERO_BLANK_EN  When defined, leading zero digits (index > 0) are blanked.
//                          Digit 0 is never blanked.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous reset, active-high
//   in_data      hex nibbles, digit i = in_data[4i+3:4i], digit 0 rightmost
//   in_dp        decimal point per digit, 1 = lit
//   in_valid     load request for in_data/in_dp
//   in_ready     1 = shadow slot free; transfer on in_valid & in_ready
//   bright       PWM duty level, 0 = dark, all-ones = full on (sampled live)
//   LED          anode select, active-low, at most one bit low
//   D_ssd        {a,b,c,d,e,f,g,dp}, active-low
//   frame_start  one-cycle pulse in the first output cycle of each digit-0 slot
module ssd_scan_driver #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SLOT_LOG2  = 12,
  parameter int unsigned BRIGHT_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BRIGHT_W-1:0]     bright,
  output logic [NUM_DIGITS-1:0]   LED,
  output logic [7:0]              D_ssd,
  output logic                    frame_start
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

  // Active-low abcdefg pattern for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      4'hF: s = 7'h38;
    endcase
    return s;
  endfunction

  // Scan state
  logic [SLOT_LOG2-1:0]    r_cnt;
  logic [IdxW-1:0]         r_idx;

  // Double buffer: active drives the display, shadow holds the next value
  logic [4*NUM_DIGITS-1:0] r_act_data;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [4*NUM_DIGITS-1:0] r_shd_data;
  logic [NUM_DIGITS-1:0]   r_shd_dp;
  logic                    r_pending;

  logic                    w_slot_end;
  logic                    w_frame_end;
  logic                    w_accept;
  logic [IdxW-1:0]         w_idx_next;
  logic [BRIGHT_W-1:0]     w_phase;
  logic                    w_lit;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_led;
  logic [6:0]              w_seg;

  assign in_ready    = ~r_pending;
  assign w_accept    = in_valid & ~r_pending;
  assign w_slot_end  = &r_cnt;
  assign w_frame_end = w_slot_end && (r_idx == LastIdx);

  always_comb begin
    w_idx_next = r_idx;
    if (w_slot_end) begin
      w_idx_next = (r_idx == LastIdx) ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_act_data <= '0;
      r_act_dp   <= '0;
      r_shd_data <= '0;
      r_shd_dp   <= '0;
      r_pending  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_idx <= w_idx_next;
      // Swap and accept are exclusive (accept needs pending low), so a load taken on
      // the boundary edge lands in the shadow and waits for the next boundary.
      if (w_frame_end && r_pending) begin
        r_act_data <= r_shd_data;
        r_act_dp   <= r_shd_dp;
        r_pending  <= 1'b0;
      end else if (w_accept) begin
        r_shd_data <= in_data;
        r_shd_dp   <= in_dp;
        r_pending  <= 1'b1;
      end
    end
  end

  // PWM: the top BRIGHT_W bits of the slot counter give the duty phase.
  assign w_phase = r_cnt[SLOT_LOG2-1 -: BRIGHT_W];
  assign w_lit   = (&bright) || (w_phase < bright);

`ifdef LEADING_ZERO_BLANK_EN
  // w_zero_up[i] = nibbles i..NUM_DIGITS-1 of the active value are all zero
  logic [NUM_DIGITS-1:0] w_zero_up;

  always_comb begin
    w_zero_up = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = i; j < NUM_DIGITS; j++) begin
        if (r_act_data[4*j +: 4] != 4'h0) begin
          w_zero_up[i] = 1'b0;
        end
      end
    end
  end
`endif

  always_comb begin
    w_nib   = '0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    w_led   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_nib    = r_act_data[4*i +: 4];
        w_dp     = r_act_dp[i];
        w_led[i] = ~w_lit;
`ifdef LEADING_ZERO_BLANK_EN
        w_blank  = (i != 0) && w_zero_up[i];
`endif
      end
    end
  end

  assign w_seg = w_blank ? 7'h7F : seg7(w_nib);

  // Registered outputs, one cycle behind (idx, cnt, active)
  always_ff @(posedge clk) begin
    if (rst) begin
      LED         <= '1;
      D_ssd       <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      LED         <= w_led;
      D_ssd       <= {w_seg, ~w_dp};
      frame_start <= (r_idx == '0) && (r_cnt == '0);
    end
  end

endmodule
